// File: rtl/cplx_mag_cordic_if.sv
// Streaming port bundle for cplx_mag_cordic: complex sample in, unsigned magnitude out.
// Widths must match the parameters of the attached cplx_mag_cordic instance.
interface cplx_mag_cordic_if #(
    parameter int INPUT_WIDTH  = 33,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH + 1
);
    logic                          valid_in;
    logic signed [INPUT_WIDTH-1:0] din_re;
    logic signed [INPUT_WIDTH-1:0] din_im;
    logic                          valid_out;
    logic [OUTPUT_WIDTH-1:0]       dout;
    logic                          sat;

    modport master (
        output valid_in, din_re, din_im,
        input  valid_out, dout, sat
    );

    modport slave (
        input  valid_in, din_re, din_im,
        output valid_out, dout, sat
    );
endinterface

// File: rtl/cplx_mag_cordic.sv
// Pipelined CORDIC vectoring magnitude: dout ~= sqrt(re^2 + im^2), one sample per clock.
// Valid travels in a shift register beside the data; no stalls, no back-pressure.
module cplx_mag_cordic #(
    parameter int INPUT_WIDTH = 33,
    parameter int ITERATIONS  = 16,
    parameter int GAIN_COMP   = 1,
    parameter int OUTPUT_REG  = 1
) (
    input  logic             clk,
    input  logic             rst,
    cplx_mag_cordic_if.slave mag
);
    localparam int OUTPUT_WIDTH = (GAIN_COMP != 0) ? INPUT_WIDTH + 1 : INPUT_WIDTH + 2;
    localparam int W = INPUT_WIDTH + 2;

    logic signed [W-1:0]     re_ext;
    logic signed [W-1:0]     im_ext;
    logic signed [W-1:0]     xs [0:ITERATIONS];
    logic signed [W-1:0]     ys [0:ITERATIONS-1];
    logic [ITERATIONS:0]     vs;
    logic [W-1:0]            m;
    logic                    vm;
    logic                    sat_now;
    logic [OUTPUT_WIDTH-1:0] mo;
    logic                    sat_q;

    assign re_ext = {{2{mag.din_re[INPUT_WIDTH-1]}}, mag.din_re};
    assign im_ext = {{2{mag.din_im[INPUT_WIDTH-1]}}, mag.din_im};

    // Left half-plane inputs are rotated by 180 degrees so the micro-rotations only
    // have to cover +-90 degrees; the final y is never needed, so it is not stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs <= '0;
            for (int i = 0; i <= ITERATIONS; i++) xs[i] <= '0;
            for (int i = 0; i < ITERATIONS; i++) ys[i] <= '0;
        end else begin
            vs    <= {vs[ITERATIONS-1:0], mag.valid_in};
            xs[0] <= re_ext[W-1] ? -re_ext : re_ext;
            ys[0] <= re_ext[W-1] ? -im_ext : im_ext;
            for (int i = 0; i < ITERATIONS; i++)
                xs[i+1] <= ys[i][W-1] ? xs[i] - (ys[i] >>> i) : xs[i] + (ys[i] >>> i);
            for (int i = 0; i < ITERATIONS - 1; i++)
                ys[i+1] <= ys[i][W-1] ? ys[i] + (xs[i] >>> i) : ys[i] - (xs[i] >>> i);
        end
    end

    generate
        if (GAIN_COMP != 0) begin : g_gain
            // 39797 / 2^16 ~= 1 / 1.646760258, the accumulated CORDIC gain
            localparam logic [W+15:0] GAIN_K = (W+16)'(39797);
            logic [W+15:0] prod;
            assign prod = {16'b0, xs[ITERATIONS]} * GAIN_K;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m  <= '0;
                    vm <= 1'b0;
                end else begin
                    m  <= W'(prod >> 16);
                    vm <= vs[ITERATIONS];
                end
            end
        end else begin : g_nogain
            assign m  = xs[ITERATIONS];
            assign vm = vs[ITERATIONS];
        end
    endgenerate

    assign sat_now = |(m >> OUTPUT_WIDTH);
    assign mo      = sat_now ? '1 : m[OUTPUT_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_q <= 1'b0;
        else if (vm && sat_now)
            sat_q <= 1'b1;
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            // dout only reloads on valid, so it keeps showing the last real result
            logic [OUTPUT_WIDTH-1:0] dout_q;
            logic                    vo_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                    vo_q   <= 1'b0;
                end else begin
                    vo_q <= vm;
                    if (vm) dout_q <= mo;
                end
            end
            assign mag.dout      = dout_q;
            assign mag.valid_out = vo_q;
            assign mag.sat       = sat_q;
        end else begin : g_nooreg
            assign mag.dout      = mo;
            assign mag.valid_out = vm;
            assign mag.sat       = sat_q | (vm & sat_now);
        end
    endgenerate

    // x only ever grows from a non-negative start, so a negative result means a datapath bug
    assert property (@(posedge clk) disable iff (rst) vs[ITERATIONS] |-> !xs[ITERATIONS][W-1]);

endmodule

// File: tb/tb_cplx_mag_cordic.sv
// Scoreboard bench for cplx_mag_cordic: three instances (IW=33 default, IW=16 default,
// IW=16 raw unregistered) driven with directed and random vectors against an integer model.
module tb_cplx_mag_cordic;
    localparam int ITER  = 16;
    localparam int LAT_A = 19;
    localparam int LAT_B = 19;
    localparam int LAT_C = 17;

    typedef struct {
        longint dout;
        bit     sat;
        longint cyc;
        real    mag;
        bit     use_mag;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cycle = 0;
    int     checks = 0;
    int     passes = 0;
    exp_t   q_a[$];
    exp_t   q_b[$];
    exp_t   q_c[$];
    exp_t   ea, eb, ec;
    longint last_a = 0;
    longint last_b = 0;
    bit     sat_a_model = 1'b0;
    bit     sat_b_model = 1'b0;
    bit     sat_c_model = 1'b0;

    cplx_mag_cordic_if #(.INPUT_WIDTH(33), .OUTPUT_WIDTH(34)) aif ();
    cplx_mag_cordic_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(17)) bif ();
    cplx_mag_cordic_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(18)) cif ();

    cplx_mag_cordic #(.INPUT_WIDTH(33), .ITERATIONS(ITER), .GAIN_COMP(1), .OUTPUT_REG(1))
        dut_a (.clk(clk), .rst(rst), .mag(aif.slave));
    cplx_mag_cordic #(.INPUT_WIDTH(16), .ITERATIONS(ITER), .GAIN_COMP(1), .OUTPUT_REG(1))
        dut_b (.clk(clk), .rst(rst), .mag(bif.slave));
    cplx_mag_cordic #(.INPUT_WIDTH(16), .ITERATIONS(ITER), .GAIN_COMP(0), .OUTPUT_REG(0))
        dut_c (.clk(clk), .rst(rst), .mag(cif.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Integer vectoring algorithm on plain 64-bit arithmetic; shifts are floor divisions.
    function automatic longint model_m(input longint re, input longint im, input int iters, input bit gain);
        longint x, y, xn;
        if (re < 0) begin
            x = -re;
            y = -im;
        end else begin
            x = re;
            y = im;
        end
        for (int i = 0; i < iters; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
            end else begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
            end
            x = xn;
        end
        return gain ? ((x * 39797) >>> 16) : x;
    endfunction

    function automatic real true_mag(input longint re, input longint im);
        real r, i;
        r = re;
        i = im;
        return $sqrt(r * r + i * i);
    endfunction

    function automatic bit accOk(input longint d, input real mag);
        real tol, rd;
        tol = 2.0 + mag / 65536.0;
        rd  = d;
        return (rd <= mag + tol) && (rd >= mag - tol);
    endfunction

    task automatic checkOutput(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (ok) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    endtask

    task automatic makeExp(input longint re, input longint im, input int ow, input bit gain,
                           input longint lat, input bit use_mag, inout bit sat_model, output exp_t e);
        longint m, maxv;
        m    = model_m(re, im, ITER, gain);
        maxv = (longint'(1) << ow) - 1;
        if (m > maxv) begin
            e.dout    = maxv;
            sat_model = 1'b1;
        end else begin
            e.dout = m;
        end
        e.sat     = sat_model;
        e.cyc     = cycle + lat;
        e.mag     = true_mag(re, im);
        e.use_mag = use_mag;
    endtask

    task automatic applyStimulusA(input bit v, input longint re, input longint im);
        exp_t e;
        @(posedge clk);
        #1;
        aif.valid_in = v;
        aif.din_re   = re[32:0];
        aif.din_im   = im[32:0];
        if (v) begin
            makeExp(re, im, 34, 1'b1, LAT_A, 1'b1, sat_a_model, e);
            q_a.push_back(e);
        end
    endtask

    task automatic applyStimulusB(input bit v, input longint re, input longint im, input bit use_mag);
        exp_t e;
        @(posedge clk);
        #1;
        bif.valid_in = v;
        bif.din_re   = re[15:0];
        bif.din_im   = im[15:0];
        if (v) begin
            makeExp(re, im, 17, 1'b1, LAT_B, use_mag, sat_b_model, e);
            q_b.push_back(e);
        end
    endtask

    task automatic applyStimulusC(input bit v, input longint re, input longint im);
        exp_t e;
        @(posedge clk);
        #1;
        cif.valid_in = v;
        cif.din_re   = re[15:0];
        cif.din_im   = im[15:0];
        if (v) begin
            makeExp(re, im, 18, 1'b0, LAT_C, 1'b0, sat_c_model, e);
            q_c.push_back(e);
        end
    endtask

    // Monitors: pop the scoreboard whenever an instance presents valid_out.
    always @(negedge clk) begin
        if (!rst) begin
            if (aif.valid_out) begin
                checkOutput(q_a.size() != 0, "a_unexpected_valid", 0, 1);
                if (q_a.size() != 0) begin
                    ea = q_a.pop_front();
                    checkOutput(aif.dout == ea.dout, "a_dout", aif.dout, ea.dout);
                    checkOutput(aif.sat == ea.sat, "a_sat", aif.sat, ea.sat);
                    checkOutput(cycle == ea.cyc, "a_latency", cycle, ea.cyc);
                    checkOutput(accOk(aif.dout, ea.mag), "a_accuracy", aif.dout, longint'($rtoi(ea.mag)));
                    last_a = ea.dout;
                end
            end else begin
                checkOutput(aif.dout == last_a, "a_dout_hold", aif.dout, last_a);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bif.valid_out) begin
                checkOutput(q_b.size() != 0, "b_unexpected_valid", 0, 1);
                if (q_b.size() != 0) begin
                    eb = q_b.pop_front();
                    checkOutput(bif.dout == eb.dout, "b_dout", bif.dout, eb.dout);
                    checkOutput(bif.sat == eb.sat, "b_sat", bif.sat, eb.sat);
                    checkOutput(cycle == eb.cyc, "b_latency", cycle, eb.cyc);
                    if (eb.use_mag)
                        checkOutput(accOk(bif.dout, eb.mag), "b_accuracy", bif.dout, longint'($rtoi(eb.mag)));
                    last_b = eb.dout;
                end
            end else begin
                checkOutput(bif.dout == last_b, "b_dout_hold", bif.dout, last_b);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cif.valid_out) begin
            checkOutput(q_c.size() != 0, "c_unexpected_valid", 0, 1);
            if (q_c.size() != 0) begin
                ec = q_c.pop_front();
                checkOutput(cif.dout == ec.dout, "c_dout", cif.dout, ec.dout);
                checkOutput(cif.sat == ec.sat, "c_sat", cif.sat, ec.sat);
                checkOutput(cycle == ec.cyc, "c_latency", cycle, ec.cyc);
            end
        end
    end

    initial begin
        logic signed [15:0] r1, r2;
        logic signed [32:0] s1, s2;
        logic [63:0]        rr;
        bit                 v;
        int                 issued;

        aif.valid_in = 1'b0; aif.din_re = '0; aif.din_im = '0;
        bif.valid_in = 1'b0; bif.din_re = '0; bif.din_im = '0;
        cif.valid_in = 1'b0; cif.din_re = '0; cif.din_im = '0;

        #12;
        checkOutput(bif.valid_out == 1'b0, "reset_valid_out", bif.valid_out, 0);
        checkOutput(bif.dout == '0, "reset_dout", bif.dout, 0);
        checkOutput(bif.sat == 1'b0, "reset_sat", bif.sat, 0);
        checkOutput(aif.valid_out == 1'b0, "reset_a_valid_out", aif.valid_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single pulse, then four back-to-back edge vectors
        applyStimulusB(1'b1, 3000, 4000, 1'b1);
        applyStimulusB(1'b0, 0, 0, 1'b0);
        repeat (LAT_B + 5) @(posedge clk);
        applyStimulusB(1'b1, -32768, -32768, 1'b1);
        applyStimulusB(1'b1, 32767, 0, 1'b1);
        applyStimulusB(1'b1, 0, -32768, 1'b1);
        applyStimulusB(1'b1, 0, 0, 1'b1);
        applyStimulusB(1'b0, 0, 0, 1'b0);
        repeat (LAT_B + 5) @(posedge clk);

        // Raw, unregistered instance
        applyStimulusC(1'b1, 32767, 32767);
        applyStimulusC(1'b1, -32768, -32768);
        applyStimulusC(1'b1, 0, 0);
        for (int k = 0; k < 300; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            applyStimulusC(v, r1, r2);
        end
        applyStimulusC(1'b0, 0, 0);
        repeat (LAT_C + 5) @(posedge clk);

        // Random 50% duty stream with bubbles
        issued = 0;
        while (issued < 10000) begin
            v  = 1'($urandom_range(0, 1));
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            applyStimulusB(v, r1, r2, 1'b0);
            if (v) issued++;
        end
        applyStimulusB(1'b0, 0, 0, 1'b0);
        repeat (LAT_B + 5) @(posedge clk);

        // Asynchronous reset in the middle of a busy stream
        for (int k = 0; k < 30; k++) begin
            r1 = 16'($urandom_range(1000, 30000));
            r2 = 16'($urandom);
            applyStimulusB(1'b1, r1, r2, 1'b0);
        end
        checkOutput(bif.valid_out == 1'b1, "b_stream_active", bif.valid_out, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput(bif.valid_out == 1'b0, "async_rst_valid_out", bif.valid_out, 0);
        checkOutput(bif.dout == '0, "async_rst_dout", bif.dout, 0);
        checkOutput(bif.sat == 1'b0, "async_rst_sat", bif.sat, 0);
        q_b.delete();
        last_b       = 0;
        sat_b_model  = 1'b0;
        bif.valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulusB(1'b1, 1234, -5678, 1'b1);
        applyStimulusB(1'b0, 0, 0, 1'b0);
        repeat (LAT_B + 5) @(posedge clk);

        // Full-width instance: extremes, then random stream
        applyStimulusA(1'b1, -(longint'(1) << 32), -(longint'(1) << 32));
        applyStimulusA(1'b1, (longint'(1) << 32) - 1, (longint'(1) << 32) - 1);
        applyStimulusA(1'b1, -(longint'(1) << 32), 0);
        applyStimulusA(1'b1, 0, -(longint'(1) << 32));
        applyStimulusA(1'b1, 0, 0);
        for (int k = 0; k < 2000; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            rr = {$urandom(), $urandom()};
            s1 = rr[32:0];
            rr = {$urandom(), $urandom()};
            s2 = rr[32:0];
            applyStimulusA(v, s1, s2);
        end
        applyStimulusA(1'b0, 0, 0);
        repeat (LAT_A + 5) @(posedge clk);

        checkOutput(q_a.size() == 0, "a_drain", q_a.size(), 0);
        checkOutput(q_b.size() == 0, "b_drain", q_b.size(), 0);
        checkOutput(q_c.size() == 0, "c_drain", q_c.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
